// File: rtl/rfm3.sv
// rfm3: register file with PC/LR specials, four combinational read ports,
// a per-register load scoreboard with decode stall, and optional forwarding
// of returning load data onto the read ports.
module rfm3 #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      AW       = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] INC      = WIDTH'(1),
    parameter bit               BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         ra,
    input  logic [AW-1:0]         rb,
    input  logic [AW-1:0]         rd,
    input  logic [AW-1:0]         rt,
    // Read-port stall qualifiers {t, d, b, a}; 'use' itself is a reserved word.
    input  logic [3:0]            use_mask,
    input  logic                  fn_inc_pc,
    input  logic                  fn_link,
    input  logic                  fn_ra_change,
    input  logic                  fn_wb,
    input  logic [WIDTH-1:0]      wb_data,
    input  logic [WIDTH-1:0]      ra_changed,
    input  logic                  ld_issue,
    input  logic [AW-1:0]         ld_dst,
    input  logic                  ld_valid,
    input  logic [AW-1:0]         ld_rd,
    input  logic [WIDTH-1:0]      ld_data,
    output logic [WIDTH-1:0]      da,
    output logic [WIDTH-1:0]      db,
    output logic [WIDTH-1:0]      dd,
    output logic [WIDTH-1:0]      dt,
    output logic [WIDTH-1:0]      pc,
    output logic [(2**AW)-1:0]    busy,
    output logic                  stall
);

    localparam int unsigned NREG   = 2 ** AW;
    localparam int unsigned PC_IDX = NREG - 1;
    localparam int unsigned LR_IDX = NREG - 2;
    localparam int unsigned NPORT  = 4;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;

    logic [AW-1:0]    addr_c  [NPORT];
    logic [WIDTH-1:0] rdata_c [NPORT];
    logic [NPORT-1:0] fwd_c;
    logic             stall_c;

    // Register next-state: load return > writeback > ra_change > PC/LR special.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (ld_valid && (ld_rd == AW'(i))) begin
                regs_d[i] = ld_data;
            end else if (fn_wb && (rd == AW'(i))) begin
                regs_d[i] = wb_data;
            end else if (fn_ra_change && (ra == AW'(i))) begin
                regs_d[i] = ra_changed;
            end else if ((i == PC_IDX) && fn_inc_pc) begin
                regs_d[i] = regs_q[PC_IDX] + INC;
            end else if ((i == LR_IDX) && fn_link) begin
                regs_d[i] = regs_q[PC_IDX];
            end
        end
    end

    // Scoreboard next-state: a new issue outranks the return of an older load.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            busy_d[i] = busy_q[i];
            if (ld_issue && (ld_dst == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (ld_valid && (ld_rd == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // Register file and scoreboard state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == PC_IDX) ? RESET_PC : '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign addr_c[0] = ra;
    assign addr_c[1] = rb;
    assign addr_c[2] = rd;
    assign addr_c[3] = rt;

    // Read ports with optional load forwarding; a forwarded port never stalls.
    always_comb begin
        stall_c = 1'b0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            fwd_c[p]   = BYPASS && ld_valid && (ld_rd == addr_c[p]);
            rdata_c[p] = fwd_c[p] ? ld_data : regs_q[addr_c[p]];
            stall_c    = stall_c | (use_mask[p] & busy_q[addr_c[p]] & ~fwd_c[p]);
        end
    end

    assign da    = rdata_c[0];
    assign db    = rdata_c[1];
    assign dd    = rdata_c[2];
    assign dt    = rdata_c[3];
    assign pc    = regs_q[PC_IDX];
    assign busy  = busy_q;
    assign stall = stall_c;

endmodule

// File: tb/tb_rfm3.sv
// tb_rfm3: drives a forwarding and a non-forwarding rfm3 with the same
// directed vectors and checks both against a behavioural model every cycle.
module tb_rfm3;

    localparam int unsigned       W    = 32;
    localparam int unsigned       A    = 4;
    localparam int unsigned       N    = 16;
    localparam logic [W-1:0]      RPC  = 32'h100;
    localparam logic [W-1:0]      STEP = 32'h1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [A-1:0] ra, rb, rd, rt, ld_dst, ld_rd;
    logic [3:0]   use_mask;
    logic         fn_inc_pc, fn_link, fn_ra_change, fn_wb, ld_issue, ld_valid;
    logic [W-1:0] wb_data, ra_changed, ld_data;

    logic [W-1:0] da0, db0, dd0, dt0, pc0, da1, db1, dd1, dt1, pc1;
    logic [N-1:0] busy0, busy1;
    logic         stall0, stall1;

    int errors = 0;
    int checks = 0;
    logic check_en = 1'b0;

    logic [W-1:0] m_r [N];
    logic [N-1:0] m_b;

    always #5 clk = ~clk;

    rfm3 #(.WIDTH(W), .AW(A), .RESET_PC(RPC), .INC(STEP), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .ra(ra), .rb(rb), .rd(rd), .rt(rt), .use_mask(use_mask),
        .fn_inc_pc(fn_inc_pc), .fn_link(fn_link), .fn_ra_change(fn_ra_change), .fn_wb(fn_wb),
        .wb_data(wb_data), .ra_changed(ra_changed), .ld_issue(ld_issue), .ld_dst(ld_dst),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .da(da0), .db(db0), .dd(dd0), .dt(dt0), .pc(pc0), .busy(busy0), .stall(stall0));

    rfm3 #(.WIDTH(W), .AW(A), .RESET_PC(RPC), .INC(STEP), .BYPASS(1'b0)) u_nob (
        .clk(clk), .reset(reset), .ra(ra), .rb(rb), .rd(rd), .rt(rt), .use_mask(use_mask),
        .fn_inc_pc(fn_inc_pc), .fn_link(fn_link), .fn_ra_change(fn_ra_change), .fn_wb(fn_wb),
        .wb_data(wb_data), .ra_changed(ra_changed), .ld_issue(ld_issue), .ld_dst(ld_dst),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .da(da1), .db(db1), .dd(dd1), .dt(dt1), .pc(pc1), .busy(busy1), .stall(stall1));

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply writes from lowest to highest priority so later ones win.
    always @(posedge clk or negedge reset) begin
        logic [W-1:0] old_pc;
        if (!reset) begin
            for (int i = 0; i < N; i++) m_r[i] = '0;
            m_r[N-1] = RPC;
            m_b = '0;
        end else begin
            old_pc = m_r[N-1];
            if (fn_inc_pc)    m_r[N-1] = old_pc + STEP;
            if (fn_link)      m_r[N-2] = old_pc;
            if (fn_ra_change) m_r[ra] = ra_changed;
            if (fn_wb)        m_r[rd] = wb_data;
            if (ld_valid)     m_r[ld_rd] = ld_data;
            if (ld_valid)     m_b[ld_rd] = 1'b0;
            if (ld_issue)     m_b[ld_dst] = 1'b1;
        end
    end

    function automatic logic [W-1:0] exp_rd(input logic [A-1:0] a, input bit byp);
        if (byp && ld_valid && ld_rd == a) return ld_data;
        return m_r[a];
    endfunction

    function automatic logic exp_stall(input bit byp);
        logic [A-1:0] ad [4];
        logic s;
        ad[0] = ra; ad[1] = rb; ad[2] = rd; ad[3] = rt;
        s = 1'b0;
        for (int p = 0; p < 4; p++)
            if (use_mask[p] && m_b[ad[p]] && !(byp && ld_valid && ld_rd == ad[p])) s = 1'b1;
        return s;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("byp.da", da0, exp_rd(ra, 1'b1));
            chk("byp.db", db0, exp_rd(rb, 1'b1));
            chk("byp.dd", dd0, exp_rd(rd, 1'b1));
            chk("byp.dt", dt0, exp_rd(rt, 1'b1));
            chk("byp.pc", pc0, m_r[N-1]);
            chk("byp.busy", W'(busy0), W'(m_b));
            chk("byp.stall", W'(stall0), W'(exp_stall(1'b1)));
            chk("nob.da", da1, exp_rd(ra, 1'b0));
            chk("nob.db", db1, exp_rd(rb, 1'b0));
            chk("nob.dd", dd1, exp_rd(rd, 1'b0));
            chk("nob.dt", dt1, exp_rd(rt, 1'b0));
            chk("nob.pc", pc1, m_r[N-1]);
            chk("nob.busy", W'(busy1), W'(m_b));
            chk("nob.stall", W'(stall1), W'(exp_stall(1'b0)));
        end
    end

    task automatic idle();
        {ra, rb, rd, rt, ld_dst, ld_rd} = '0;
        use_mask = '0;
        {fn_inc_pc, fn_link, fn_ra_change, fn_wb, ld_issue, ld_valid} = '0;
        wb_data = '0; ra_changed = '0; ld_data = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        repeat (2) cyc();
        reset = 1'b1;
        check_en = 1'b1;
        cyc();

        // PC=0x10, then inc+link together.
        fn_wb = 1; rd = 4'd15; wb_data = 32'h10;
        cyc(); idle();
        fn_inc_pc = 1; fn_link = 1;
        cyc(); idle();
        ra = 4'd14; #1;
        chk("lit.inc_pc", pc0, 32'h11);
        chk("lit.link_lr", da0, 32'h10);
        // Writeback to PC overrides increment.
        fn_inc_pc = 1; fn_wb = 1; rd = 4'd15; wb_data = 32'h50;
        cyc(); idle(); #1;
        chk("lit.wb_over_inc", pc0, 32'h50);

        // Write priority on r3.
        ld_valid = 1; ld_rd = 4'd3; ld_data = 32'hA;
        fn_wb = 1; rd = 4'd3; wb_data = 32'hB;
        fn_ra_change = 1; ra = 4'd3; ra_changed = 32'hC;
        cyc(); idle(); ra = 4'd3; #1;
        chk("lit.prio_ld", da0, 32'hA);
        fn_wb = 1; rd = 4'd3; wb_data = 32'hB;
        fn_ra_change = 1; ra = 4'd3; ra_changed = 32'hC;
        cyc(); idle(); ra = 4'd3; #1;
        chk("lit.prio_wb", da0, 32'hB);

        // Scoreboard and stall.
        ld_issue = 1; ld_dst = 4'd5;
        cyc(); idle(); rb = 4'd5; use_mask = 4'b0010; #1;
        chk("lit.busy5_set", W'(busy0[5]), 32'h1);
        chk("lit.stall_used", W'(stall0), 32'h1);
        use_mask = 4'b0000; #1;
        chk("lit.stall_unused", W'(stall0), 32'h0);
        use_mask = 4'b0010; ld_valid = 1; ld_rd = 4'd5; ld_data = 32'h1234; #1;
        chk("lit.fwd_db", db0, 32'h1234);
        chk("lit.fwd_nostall", W'(stall0), 32'h0);
        chk("lit.nob_stall", W'(stall1), 32'h1);
        chk("lit.nob_db_old", db1, 32'h0);
        cyc(); idle(); rb = 4'd5; #1;
        chk("lit.busy5_clr", W'(busy0[5]), 32'h0);
        chk("lit.r5", db0, 32'h1234);

        // Simultaneous issue and return on r7.
        ld_issue = 1; ld_dst = 4'd7; ld_valid = 1; ld_rd = 4'd7; ld_data = 32'h77;
        cyc(); idle(); rt = 4'd7; use_mask = 4'b1000; #1;
        chk("lit.busy7_kept", W'(busy0[7]), 32'h1);
        chk("lit.r7", dt0, 32'h77);
        chk("lit.stall7", W'(stall0), 32'h1);
        ld_valid = 1; ld_rd = 4'd7; ld_data = 32'h99;
        cyc(); idle();

        // PC wraps on overflow.
        fn_wb = 1; rd = 4'd15; wb_data = 32'hFFFF_FFFF;
        cyc(); idle();
        fn_inc_pc = 1;
        cyc(); idle(); #1;
        chk("lit.pc_wrap", pc0, 32'h0);

        // Mixed vectors, checked by the per-cycle compare.
        for (int k = 0; k < 200; k++) begin
            ra = A'($urandom); rb = A'($urandom); rd = A'($urandom); rt = A'($urandom);
            use_mask = 4'($urandom);
            fn_inc_pc = 1'($urandom); fn_link = 1'($urandom);
            fn_ra_change = 1'($urandom); fn_wb = 1'($urandom);
            wb_data = $urandom; ra_changed = $urandom;
            ld_issue = 1'($urandom); ld_dst = A'($urandom);
            ld_valid = 1'($urandom); ld_rd = A'($urandom); ld_data = $urandom;
            cyc();
        end
        idle();

        // Asynchronous reset mid-cycle.
        #2 reset = 1'b0; #1;
        chk("lit.rst_pc", pc0, RPC);
        chk("lit.rst_busy", W'(busy0), 32'h0);
        chk("lit.rst_stall", W'(stall0), 32'h0);
        for (int i = 0; i < 14; i++) begin
            ra = A'(i); rb = A'(i); rd = A'(i); rt = A'(i); #1;
            chk("lit.rst_rd", da0 | db0 | dd0 | dt0, 32'h0);
        end
        cyc();
        reset = 1'b1;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rfm3.md
Name: rfm3

Overview:
- Parametrised next-generation CPU register file: 2**AW general registers of WIDTH bits and four combinational read ports (a, b, d, t).
- Top register is the PC, with a configurable increment step. The register below it is the link register (LR).
- Adds a load scoreboard: one busy bit per register, set when a load is issued and cleared when load data returns, plus a stall output for the decode stage.
- Optional forwarding of returning load data onto the read ports.

Parameters:
- WIDTH, 32, register data width in bits.
- AW, 4, register address width; NREG = 2**AW; PC index = NREG-1; LR index = NREG-2.
- RESET_PC, 0, PC value after reset.
- INC, 1, amount added to PC on fn_inc_pc; modulo 2**WIDTH.
- BYPASS, 1, 1 = forward ld_data onto read ports and suppress its stall; 0 = no forwarding.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ra, rb, rd, rt  in  AW each  read addresses for ports a, b, d, t; ra also addresses the ra_change write, rd the wb write.
- use  in  4  read-port qualifiers for stall; bit0=a, bit1=b, bit2=d, bit3=t.
- fn_inc_pc  in  1  PC <= PC+INC.
- fn_link  in  1  LR <= current PC.
- fn_ra_change  in  1  r[ra] <= ra_changed.
- fn_wb  in  1  r[rd] <= wb_data.
- wb_data, ra_changed  in  WIDTH each  write data.
- ld_issue  in  1  load issued to register ld_dst; sets busy[ld_dst].
- ld_dst  in  AW  destination of the issued load.
- ld_valid  in  1  load data returning this cycle; always accepted.
- ld_rd  in  AW  destination of the returning load.
- ld_data  in  WIDTH  returning load data.
- da, db, dd, dt  out  WIDTH each  read data.
- pc  out  WIDTH  r[NREG-1].
- busy  out  NREG  scoreboard bits.
- stall  out  1  a used read port references a busy register.

Behaviour:
- Reset (reset=0, async): all registers 0 except PC=RESET_PC; busy=0. da/db/dd/dt then show the reset contents; stall=0.
- Reads are combinational, with zero latency to stored values. A write becomes visible the cycle after its clock edge.
- Per-register write priority in one cycle, highest first:
  1. ld_valid & ld_rd==i
  2. fn_wb & rd==i
  3. fn_ra_change & ra==i
  4. special: fn_link for LR, fn_inc_pc for PC
- Lower-priority writes to the same register are dropped. Writes to different registers proceed in parallel.
- fn_link and fn_inc_pc together: LR <= old PC, PC <= old PC+INC.
- A higher-priority write to PC overrides the increment. PC wraps to 0 on overflow.
- Scoreboard, next busy[i]:
  - 1 if ld_issue & ld_dst==i.
  - Else 0 if ld_valid & ld_rd==i.
  - Else unchanged.
  - Issue and return on the same register in the same cycle leaves busy set, because the new load is outstanding.
- ld_valid to a non-busy register still writes the data and busy stays 0. fn_wb/fn_ra_change to a busy register write normally and leave busy unchanged.
- stall = OR over ports p of use[p] & busy[addr_p] & !fwd_p, where:
  - addr_p is the address of port p (ra/rb/rd/rt).
  - fwd_p = BYPASS & ld_valid & ld_rd==addr_p.
- Forwarding: when fwd_p=1, port p returns ld_data instead of the stored value. With BYPASS=0 no forwarding occurs and fwd_p is always 0.
- pc output is never forwarded.

Test Plan:
- Reset: drive reset=0 mid-run with RESET_PC=0x100. pc=0x100 and busy=0 immediately without a clock edge; all ports read 0 for r0..r13.
- Inc+link: PC=0x10, fn_inc_pc=fn_link=1 for one cycle. Next cycle pc=0x11 and r14=0x10. With fn_wb rd=15 wb_data=0x50 in the same cycle, pc=0x50 instead.
- Priority: same cycle ld_valid ld_rd=3 ld_data=0xA, fn_wb rd=3 wb_data=0xB, fn_ra_change ra=3 ra_changed=0xC. Then r3=0xA. Repeat without ld_valid: r3=0xB.
- Scoreboard/stall: ld_issue ld_dst=5. Next cycle busy[5]=1; rb=5 use=4'b0010 gives stall=1; use=0 gives stall=0.
- Load return with BYPASS=1: ld_valid ld_rd=5 ld_data=0x1234 gives db=0x1234 and stall=0 in the same cycle; next cycle busy[5]=0 and r5=0x1234. With BYPASS=0, stall=1 during that cycle.
- Simultaneous issue and return: ld_issue ld_dst=7 with ld_valid ld_rd=7 in one cycle. Then busy[7] stays 1 and r7 holds ld_data.
